// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - two-stage pipelined barrel shifter with valid/ready handshakes
module shifter_pipe #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int SPLIT   = SHAMT_W / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_err
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // Shared shift core; SRA fill comes from the explicit sign argument so the
  // second stage can use the sign captured from the original operand.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] k,
    input logic [2:0]         op,
    input logic               sign
  );
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   fill;
    shift_by = '0;
    dd       = {d, d};
    fill     = ~({WIDTH{1'b1}} >> k);
    case (op)
      OP_SLL: shift_by = d << k;
      OP_SRL: shift_by = d >> k;
      OP_SRA: shift_by = (d >> k) | (sign ? fill : '0);
      OP_ROL: begin
        dd       = dd << k;
        shift_by = dd[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dd       = dd >> k;
        shift_by = dd[WIDTH-1:0];
      end
      default: shift_by = '0;
    endcase
  endfunction

  logic               s1_valid_q;
  logic [WIDTH-1:0]   s1_data_q;
  logic [WIDTH-1:0]   s1_data_d;
  logic [SPLIT-1:0]   s1_lo_q;
  logic [2:0]         s1_op_q;
  logic               s1_sign_q;
  logic               s1_err_q;
  logic               s1_err_d;
  logic [SHAMT_W-1:0] s1_hi_amt;

  logic               s2_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [WIDTH-1:0]   out_data_d;
  logic               out_zero_q;
  logic               out_zero_d;
  logic               out_err_q;
  logic [SHAMT_W-1:0] s2_lo_amt;

  logic               s1_adv;
  logic               s2_adv;

  // Ready chain plus the next-state data for both stages.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv && !rst;

    s1_hi_amt  = {in_shamt[SHAMT_W-1:SPLIT], {SPLIT{1'b0}}};
    s1_err_d   = (in_op > OP_ROR);
    s1_data_d  = shift_by(in_data, s1_hi_amt, in_op, in_data[WIDTH-1]);

    s2_lo_amt  = {{(SHAMT_W-SPLIT){1'b0}}, s1_lo_q};
    out_data_d = s1_err_q ? '0 : shift_by(s1_data_q, s2_lo_amt, s1_op_q, s1_sign_q);
    out_zero_d = (out_data_d == '0);
  end

  // Stage 1: coarse shift by the upper shamt bits; holds while stage 2 is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_lo_q    <= '0;
      s1_op_q    <= '0;
      s1_sign_q  <= 1'b0;
      s1_err_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= s1_data_d;
        s1_lo_q   <= in_shamt[SPLIT-1:0];
        s1_op_q   <= in_op;
        s1_sign_q <= in_data[WIDTH-1];
        s1_err_q  <= s1_err_d;
      end
    end
  end

  // Stage 2: fine shift by the low shamt bits into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_zero_q <= 1'b1;
      out_err_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        out_zero_q <= out_zero_d;
        out_err_q  <= s1_err_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - scoreboard bench for shifter_pipe at WIDTH 32, 8 and 4
module tb_shifter_pipe;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        e;
    int          acc;
    bit          lat;
    int          tag;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    int          k;
    logic [31:0] xd;
    logic        xz;
    logic        xe;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  logic        iv[3];
  logic        ir[3];
  logic        ov[3];
  logic        ordy[3];
  logic        oz[3];
  logic        oe[3];
  logic [31:0] id[3];
  logic [4:0]  ik[3];
  logic [2:0]  iop[3];
  logic [31:0] od32;
  logic [7:0]  od8;
  logic [3:0]  od4;
  logic        ordy_set[3];
  logic        rnd_bit[3];
  bit          rand_bp;
  bit          chk_lat;

  int n_err = 0;
  int n_chk = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  assign ordy[0] = rand_bp ? rnd_bit[0] : ordy_set[0];
  assign ordy[1] = rand_bp ? rnd_bit[1] : ordy_set[1];
  assign ordy[2] = rand_bp ? rnd_bit[2] : ordy_set[2];

  shifter_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_shamt(ik[0]), .in_op(iop[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od32), .out_zero(oz[0]), .out_err(oe[0])
  );

  shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1][7:0]),
    .in_shamt(ik[1][2:0]), .in_op(iop[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od8), .out_zero(oz[1]), .out_err(oe[1])
  );

  shifter_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2][3:0]),
    .in_shamt(ik[2][1:0]), .in_op(iop[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od4), .out_zero(oz[2]), .out_err(oe[2])
  );

  function automatic int wid(int j);
    return (j == 0) ? 32 : ((j == 1) ? 8 : 4);
  endfunction

  function automatic logic [31:0] get_od(int j);
    case (j)
      0:       return od32;
      1:       return {24'h0, od8};
      default: return {28'h0, od4};
    endcase
  endfunction

  // Bitwise reference: each result bit is looked up from its source position.
  function automatic logic [31:0] ref_shift(int w, logic [31:0] d, int k, int op);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        0: begin src = i - k; if (src >= 0) r[i] = d[src]; end
        1: begin src = i + k; if (src < w) r[i] = d[src]; end
        2: begin src = i + k; if (src < w) r[i] = d[src]; else r[i] = d[w-1]; end
        3: r[i] = d[(i - k + w) % w];
        4: r[i] = d[(i + k) % w];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(logic [31:0] d, logic z, logic e, int tag);
    exp_t x;
    x.d = d; x.z = z; x.e = e; x.acc = 0; x.lat = 1'b0; x.tag = tag;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sb_push(int j, exp_t e);
    case (j)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int sb_size(int j);
    case (j)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_pop(int j, output exp_t e);
    case (j)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic sb_clear(int j);
    case (j)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 3; j++) rnd_bit[j] = 1'($urandom_range(0, 1));
  end

  logic [31:0] hold_d[3];
  logic        hold_z[3];
  logic        hold_e[3];
  bit          stalled[3];

  // Output monitor: stall stability, then ordered compare against the scoreboard.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        sb_clear(j);
        stalled[j] = 1'b0;
      end else begin
        if (stalled[j]) begin
          check($sformatf("stall_valid j%0d", j), 32'(ov[j]), 32'd1);
          check($sformatf("stall_data j%0d", j), get_od(j), hold_d[j]);
          check($sformatf("stall_zero j%0d", j), 32'(oz[j]), 32'(hold_z[j]));
          check($sformatf("stall_err j%0d", j), 32'(oe[j]), 32'(hold_e[j]));
        end
        if (ov[j] && ordy[j]) begin
          if (sb_size(j) == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_out j%0d @cyc %0d: got data %h with empty scoreboard", j, cyc, get_od(j));
          end else begin
            exp_t e;
            sb_pop(j, e);
            check($sformatf("out_data j%0d tag%0d", j, e.tag), get_od(j), e.d);
            check($sformatf("out_zero j%0d tag%0d", j, e.tag), 32'(oz[j]), 32'(e.z));
            check($sformatf("out_err j%0d tag%0d", j, e.tag), 32'(oe[j]), 32'(e.e));
            if (e.lat) check($sformatf("latency j%0d tag%0d", j, e.tag), 32'(cyc - e.acc), 32'd2);
          end
        end
        stalled[j] = ov[j] && !ordy[j];
        hold_d[j]  = get_od(j);
        hold_z[j]  = oz[j];
        hold_e[j]  = oe[j];
      end
    end
  end

  task automatic offer(int j, logic [31:0] d, int k, logic [2:0] op, exp_t e, output bit acc);
    iv[j]  = 1'b1;
    id[j]  = d;
    ik[j]  = k[4:0];
    iop[j] = op;
    @(negedge clk);
    acc = iv[j] && ir[j];
    if (acc) begin
      e.acc = cyc;
      e.lat = chk_lat;
      sb_push(j, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int j, logic [31:0] d, int k, logic [2:0] op, exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      offer(j, d, k, op, e, acc);
      n++;
    end
    iv[j] = 1'b0;
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout j%0d tag%0d: got no accept in %0d cycles", j, e.tag, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_size(0) + sb_size(1) + sb_size(2)) != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb_size(0) + sb_size(1) + sb_size(2)), 32'd0);
  endtask

  vec_t tbl[16];

  initial begin
    logic [31:0] d;
    logic [31:0] x;
    int          k;
    int          op;
    int          nb;
    bit          acc;

    tbl[0]  = '{3'd0, 32'h0000000F, 31, 32'h80000000, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 32'hF0000000, 28, 32'h0000000F, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 32'h80000000, 4,  32'hF8000000, 1'b0, 1'b0};
    tbl[3]  = '{3'd2, 32'h7FFFFFFF, 31, 32'h00000000, 1'b1, 1'b0};
    tbl[4]  = '{3'd3, 32'h80000001, 1,  32'h00000003, 1'b0, 1'b0};
    tbl[5]  = '{3'd4, 32'h00000001, 1,  32'h80000000, 1'b0, 1'b0};
    tbl[6]  = '{3'd7, 32'hDEADBEEF, 5,  32'h00000000, 1'b1, 1'b1};
    tbl[7]  = '{3'd0, 32'h12345678, 0,  32'h12345678, 1'b0, 1'b0};
    tbl[8]  = '{3'd4, 32'h12345678, 4,  32'h81234567, 1'b0, 1'b0};
    tbl[9]  = '{3'd2, 32'h80000000, 7,  32'hFF000000, 1'b0, 1'b0};
    tbl[10] = '{3'd3, 32'h0000ABCD, 16, 32'hABCD0000, 1'b0, 1'b0};
    tbl[11] = '{3'd4, 32'h000000F0, 6,  32'hC0000003, 1'b0, 1'b0};
    tbl[12] = '{3'd1, 32'h80000000, 31, 32'h00000001, 1'b0, 1'b0};
    tbl[13] = '{3'd2, 32'h87654321, 0,  32'h87654321, 1'b0, 1'b0};
    tbl[14] = '{3'd5, 32'h12345678, 0,  32'h00000000, 1'b1, 1'b1};
    tbl[15] = '{3'd0, 32'h00000001, 5,  32'h00000020, 1'b0, 1'b0};

    rst     = 1'b1;
    rand_bp = 1'b0;
    chk_lat = 1'b1;
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0; id[j] = '0; ik[j] = '0; iop[j] = '0;
      ordy_set[j] = 1'b1; rnd_bit[j] = 1'b1;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", od32, 32'h0);
    check("rst_out_zero", 32'(oz[0]), 32'd1);
    check("rst_out_err", 32'(oe[0]), 32'd0);
    check("rst_in_ready", 32'(ir[0]), 32'd0);
    check("rst_out_data8", get_od(1), 32'h0);
    check("rst_out_data4", get_od(2), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(ir[0]), 32'd1);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 16; i++)
      send(0, tbl[i].d, tbl[i].k, tbl[i].op, mk_exp(tbl[i].xd, tbl[i].xz, tbl[i].xe, i));
    drain();

    // Eight-beat stream at full throughput.
    for (int i = 0; i < 8; i++) begin
      d  = $urandom;
      k  = $urandom_range(0, 31);
      op = $urandom_range(0, 4);
      x  = ref_shift(32, d, k, op);
      offer(0, d, k, 3'(op), mk_exp(x, x == 0, 1'b0, 100 + i), acc);
      check($sformatf("stream_in_ready beat%0d", i), 32'(acc), 32'd1);
    end
    iv[0] = 1'b0;
    drain();

    // Five stalled cycles with beats offered throughout: only two fit.
    chk_lat = 1'b0;
    ordy_set[0] = 1'b0;
    nb = 0;
    for (int c = 0; c < 5; c++) begin
      d = 32'h01010101 * (nb + 1);
      offer(0, d, nb + 1, 3'd3, mk_exp(ref_shift(32, d, nb + 1, 3), 1'b0, 1'b0, 200 + nb), acc);
      if (acc) nb++;
    end
    check("stall_accepts", 32'(nb), 32'd2);
    check("stall_in_ready", 32'(ir[0]), 32'd0);
    ordy_set[0] = 1'b1;
    d = 32'h01010101 * (nb + 1);
    send(0, d, nb + 1, 3'd3, mk_exp(ref_shift(32, d, nb + 1, 3), 1'b0, 1'b0, 200 + nb));
    drain();

    // Reset with two beats in flight and the consumer stalled.
    ordy_set[0] = 1'b0;
    send(0, 32'h11111111, 1, 3'd0, mk_exp(32'h22222222, 1'b0, 1'b0, 300));
    send(0, 32'h22222222, 1, 3'd0, mk_exp(32'h44444444, 1'b0, 1'b0, 301));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(ov[0]), 32'd0);
    check("mid_rst_out_data", od32, 32'h0);
    check("mid_rst_out_zero", 32'(oz[0]), 32'd1);
    check("mid_rst_in_ready", 32'(ir[0]), 32'd0);
    rst = 1'b0;
    ordy_set[0] = 1'b1;
    chk_lat = 1'b1;
    #1;
    check("mid_rst_release_in_ready", 32'(ir[0]), 32'd1);
    send(0, 32'h80000000, 7, 3'd2, mk_exp(32'hFF000000, 1'b0, 1'b0, 302));
    drain();

    // Sweep of all legal ops and shift amounts with random backpressure.
    chk_lat = 1'b0;
    rand_bp = 1'b1;
    for (int j = 0; j < 3; j++) begin
      int w;
      logic [31:0] mask;
      w = wid(j);
      mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
      for (int o = 0; o < 5; o++) begin
        for (int kk = 0; kk < w; kk++) begin
          for (int r = 0; r < 2; r++) begin
            d = $urandom & mask;
            x = ref_shift(w, d, kk, o);
            if ($urandom_range(0, 3) == 0) begin
              iv[j] = 1'b0;
              @(posedge clk);
              #1;
            end
            send(j, d, kk, 3'(o), mk_exp(x, x == 0, 1'b0, 1000 * (j + 1) + 100 * o + kk));
          end
        end
      end
    end
    rand_bp = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion by cycle %0d expected finish earlier", cyc);
    $fatal(1);
  end

endmodule
